// File: rtl/kernel_pr_dataflow_start_ctrl_if.sv
// Host handshake, start-token FIFO and sink-completion signals of the kernel_pr
// dataflow start sequencer, bundled with master (host/FIFO side) and slave (controller) views.
interface kernel_pr_dataflow_start_ctrl_if #(
  parameter int NUM_CH = 3
) ();
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_continue;
  logic              ap_idle;
  logic [NUM_CH-1:0] start_write;
  logic [NUM_CH-1:0] start_full_n;
  logic              sink_done;
  logic              err;

  modport master (
    output ap_start, ap_continue, start_full_n, sink_done,
    input  ap_ready, ap_done, ap_idle, start_write, err
  );

  modport slave (
    input  ap_start, ap_continue, start_full_n, sink_done,
    output ap_ready, ap_done, ap_idle, start_write, err
  );
endinterface

// File: rtl/kernel_pr_dataflow_start_ctrl.sv
// Dataflow start sequencer: issues one start token per channel per iteration and tracks
// in-flight/completed iterations. Optional perf counters under KERNEL_PR_START_CTRL_PERF_EN.
module kernel_pr_dataflow_start_ctrl #(
  parameter int NUM_CH       = 3,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  kernel_pr_dataflow_start_ctrl_if.slave       bus
`ifdef KERNEL_PR_START_CTRL_PERF_EN
  ,
  output logic [31:0]                          iter_cnt,
  output logic [31:0]                          stall_cnt
`endif
);

  typedef enum logic [0:0] {
    S_WAIT  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t              state_r, state_next_s;
  logic [NUM_CH-1:0]   mask_r, mask_next_s, merged_s;
  logic [NUM_CH-1:0]   start_write_s;
  logic [CNT_W-1:0]    inflight_r, done_cnt_r;
  logic                err_r;
  logic                ap_ready_s, ap_done_s, cont_s, sink_ok_s, err_set_s;

  assign ap_done_s = (done_cnt_r != {CNT_W{1'b0}});
  assign cont_s    = ap_done_s & bus.ap_continue;
  // A completion beyond the number of issued iterations is a protocol error and is dropped.
  assign err_set_s = bus.sink_done & (done_cnt_r == inflight_r);
  assign sink_ok_s = bus.sink_done & ~err_set_s;

  // Next-state, per-channel write strobes and ready pulse.
  always_comb begin
    state_next_s  = state_r;
    mask_next_s   = mask_r;
    start_write_s = {NUM_CH{1'b0}};
    merged_s      = mask_r;
    ap_ready_s    = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (bus.ap_start && (inflight_r < CNT_W'(MAX_INFLIGHT))) begin
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_ISSUE: begin
        start_write_s = ~mask_r & bus.start_full_n;
        merged_s      = mask_r | start_write_s;
        if (&merged_s) begin
          ap_ready_s   = 1'b1;
          mask_next_s  = {NUM_CH{1'b0}};
          state_next_s = S_WAIT;
        end else begin
          mask_next_s  = merged_s;
          state_next_s = S_ISSUE;
        end
      end
      default: begin
        state_next_s = S_WAIT;
        mask_next_s  = {NUM_CH{1'b0}};
      end
    endcase
  end

  // State, issue mask, in-flight/done counters and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_WAIT;
      mask_r     <= {NUM_CH{1'b0}};
      inflight_r <= {CNT_W{1'b0}};
      done_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      mask_r  <= mask_next_s;
      case ({ap_ready_s, cont_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
      case ({sink_ok_s, cont_s})
        2'b10:   done_cnt_r <= done_cnt_r + CNT_W'(1);
        2'b01:   done_cnt_r <= done_cnt_r - CNT_W'(1);
        default: done_cnt_r <= done_cnt_r;
      endcase
      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.start_write = start_write_s;
  assign bus.ap_ready    = ap_ready_s;
  assign bus.ap_done     = ap_done_s;
  assign bus.ap_idle     = (state_r == S_WAIT) && (inflight_r == {CNT_W{1'b0}});
  assign bus.err         = err_r;

`ifdef KERNEL_PR_START_CTRL_PERF_EN
  logic [31:0] iter_cnt_r, stall_cnt_r;
  logic        stall_s;

  // A stall cycle is an issue cycle where some still-unissued channel is full.
  assign stall_s = (state_r == S_ISSUE) && (|(~mask_r & ~bus.start_full_n));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_cnt_r  <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (cont_s && (iter_cnt_r != 32'hFFFF_FFFF)) begin
        iter_cnt_r <= iter_cnt_r + 32'd1;
      end else begin
        iter_cnt_r <= iter_cnt_r;
      end
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign iter_cnt  = iter_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_kernel_pr_dataflow_start_ctrl.sv
// Scoreboard bench for kernel_pr_dataflow_start_ctrl (NUM_CH=3, MAX_INFLIGHT=2); the
// perf-counter scenario is compiled in when KERNEL_PR_START_CTRL_PERF_EN is defined.
module tb_kernel_pr_dataflow_start_ctrl;

  typedef struct packed {
    logic [2:0] sw;
    logic       rdy;
    logic       done;
    logic       idle;
    logic       err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  kernel_pr_dataflow_start_ctrl_if #(.NUM_CH(3)) bus ();

`ifdef KERNEL_PR_START_CTRL_PERF_EN
  logic [31:0] iter_cnt;
  logic [31:0] stall_cnt;
`endif

  kernel_pr_dataflow_start_ctrl #(
    .NUM_CH(3),
    .MAX_INFLIGHT(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef KERNEL_PR_START_CTRL_PERF_EN
    ,
    .iter_cnt(iter_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, queue the expected
  // outputs for this cycle, compare them on the falling edge.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic [2:0] fn,
                     input logic sd, input logic cont, input logic [2:0] e_sw,
                     input logic e_rdy, input logic e_done, input logic e_idle, input logic e_err);
    exp_t e;
    exp_t got;
    reset            = rst;
    bus.ap_start     = st;
    bus.start_full_n = fn;
    bus.sink_done    = sd;
    bus.ap_continue  = cont;
    e.sw = e_sw; e.rdy = e_rdy; e.done = e_done; e.idle = e_idle; e.err = e_err;
    exp_q.push_back(e);
    @(negedge clk);
    got.sw = bus.start_write; got.rdy = bus.ap_ready; got.done = bus.ap_done;
    got.idle = bus.ap_idle; got.err = bus.err;
    e = exp_q.pop_front();
    check({tag, ".start_write"}, 32'(got.sw),   32'(e.sw));
    check({tag, ".ap_ready"},    32'(got.rdy),  32'(e.rdy));
    check({tag, ".ap_done"},     32'(got.done), 32'(e.done));
    check({tag, ".ap_idle"},     32'(got.idle), 32'(e.idle));
    check({tag, ".err"},         32'(got.err),  32'(e.err));
    @(posedge clk);
    #1;
  endtask

  // Complete the single in-flight iteration: sink_done, then continue, then settle.
  task automatic complete_one(input string tag, input logic e_err);
    cyc({tag, ".sink"}, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, e_err);
    cyc({tag, ".cont"}, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, e_err);
    cyc({tag, ".idle"}, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, e_err);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.ap_start     = 1'b0;
    bus.ap_continue  = 1'b0;
    bus.sink_done    = 1'b0;
    bus.start_full_n = 3'b111;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    // Reset state
    cyc("rst", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single iteration, all FIFOs ready
    cyc("t1.c0", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t1.c1", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      cyc($sformatf("t1.wait%0d", i), 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t1.sink", 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("t1.done%0d", i), 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t1.cont", 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t1.idle", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Staggered back-pressure: channel 1 full for the first issue cycles
    cyc("t2.c0", 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t2.c1", 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("t2.stall%0d", i), 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t2.c6", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t2.c7", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    complete_one("t2", 1'b0);

    // In-flight limit with ap_start held high
    cyc("t3.c0", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t3.c1", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t3.c2", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3.c3", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("t3.hold%0d", i), 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3.sink", 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3.cont", 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t3.c9",   1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3.c10",  1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t3.c11",  1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous sink_done and continue with one completion pending
    cyc("t4.sink",  1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t4.both",  1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t4.cont2", 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("t4.clr",   1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t4.stray", 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t4.noerr", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Spurious completion sets err; reset mid-issue clears everything
    cyc("t5.bad",   1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t5.err",   1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("t5.start", 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("t5.part",  1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("t5.stall", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("t5.rst",   1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("t5.post",  1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t5.c0",    1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t5.c1",    1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t5.c2",    1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    complete_one("t5", 1'b0);

`ifdef KERNEL_PR_START_CTRL_PERF_EN
    // Three iterations, channel 0 full for four issue cycles in the second one
    do_reset();
    for (int it = 0; it < 3; it++) begin
      if (it == 1) begin
        cyc("p.c0", 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("p.c1", 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
          cyc("p.stall", 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("p.c5", 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        cyc("p.c0", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("p.c1", 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      complete_one("p", 1'b0);
    end
    check("perf.iter_cnt",  iter_cnt,  32'd3);
    check("perf.stall_cnt", stall_cnt, 32'd4);
`endif

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_pr_dataflow_start_ctrl.md
Name: kernel_pr_dataflow_start_ctrl

Overview:
- Top-level dataflow start sequencer for a kernel_pr iteration.
- Takes the ap_start/ap_continue handshake from the host, writes one start token into each of NUM_CH start-token FIFOs (shift-register FIFOs with a write/full_n interface), and tracks iterations in flight.
- Collects completion pulses from the sink process (write_back) and returns ap_done/ap_ready/ap_idle.

Parameters:
- NUM_CH, 3, number of downstream start-token FIFOs driven (1..16).
- MAX_INFLIGHT, 2, maximum iterations issued but not yet acknowledged via ap_continue (1..15).
- CNT_W, 4, width of the in-flight and done counters; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ap_start  input  1  host request for a new iteration; level, held until ap_ready.
- ap_ready  output  1  one-cycle pulse: all tokens for the current iteration are written.
- ap_done  output  1  at least one completed iteration is awaiting ap_continue.
- ap_continue  input  1  host acknowledges one completed iteration while ap_done=1.
- ap_idle  output  1  nothing in flight and no partial issue.
- start_write  output  NUM_CH  per-channel write strobe to the start FIFO.
- start_full_n  input  NUM_CH  per-channel not-full flag from the start FIFO.
- sink_done  input  1  one-cycle pulse from the final process per finished iteration.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=S_WAIT, issued mask=0, inflight=0, done_cnt=0, err=0.
  - Outputs: ap_ready=0, ap_done=0, ap_idle=1, start_write=0.
  - A reset mid-issue discards any partial mask. The start FIFOs share this reset, so no tokens are orphaned.
- FSM states:
  - S_WAIT: start_write=0. Go to S_ISSUE when ap_start=1 and inflight<MAX_INFLIGHT; otherwise stay.
  - S_ISSUE: start_write[i] = ~mask[i] & start_full_n[i] (combinational), and mask <= mask | start_write.
    - If (mask | start_write) is all ones: ap_ready=1 this cycle, mask<=0, inflight increments, next state S_WAIT.
    - Otherwise: stay in S_ISSUE. Channels may complete in different cycles.
    - A channel whose full_n stays 0 stalls the iteration indefinitely, and no channel is ever written twice per iteration.
    - ap_start is not re-sampled in S_ISSUE; dropping it mid-issue does not abort the issue.
- Latency:
  - ap_start rising at cycle t with all FIFOs not full gives start_write=all ones and ap_ready at t+1.
  - Back-to-back iterations with ap_start held need a minimum of 2 cycles each.
- Completion:
  - sink_done increments done_cnt.
  - ap_done = (done_cnt != 0).
  - ap_done & ap_continue decrements both done_cnt and inflight.
  - Simultaneous sink_done and continue leave done_cnt unchanged.
  - Simultaneous ap_ready increment and continue decrement leave inflight unchanged.
- Back-pressure:
  - inflight==MAX_INFLIGHT holds the FSM in S_WAIT.
  - A continue in the same cycle does not release the FSM; the new issue starts the following cycle.
- ap_idle = (state==S_WAIT) & (inflight==0). It is combinational from registers.
- Errors (err set, sticky until reset):
  - sink_done with done_cnt==inflight: more completions than issues. The pulse is ignored.
  - ap_continue with ap_done=0: ignored, but it does not set err.
- Counters never wrap; all increments and decrements are guarded as above.

Optional Feature:
- Macro: KERNEL_PR_START_CTRL_PERF_EN.
- When defined:
  - Adds output iter_cnt [31:0], counting ap_done&ap_continue events.
  - Adds output stall_cnt [31:0], counting S_ISSUE cycles where some unissued channel has full_n=0.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: neither port nor their logic exists, and all other behaviour is identical.

Test Plan:
- Single iteration: NUM_CH=3, all full_n=1, ap_start pulse held until ap_ready.
  - start_write=3'b111 and ap_ready for exactly one cycle, at t+1; ap_idle drops to 0.
  - sink_done 10 cycles later gives ap_done=1 until ap_continue; after continue, ap_idle=1.
- Staggered back-pressure: full_n=3'b101 for 5 cycles, then 3'b111.
  - start_write=3'b101 once, then 3'b010 once, 5 cycles later.
  - ap_ready coincides with the 3'b010 write; no channel is written twice.
- Inflight limit: MAX_INFLIGHT=2, ap_start held high, no sink_done.
  - Exactly 2 ap_ready pulses, the second one 2 cycles after the first; then stall.
  - sink_done followed by ap_continue in cycle c gives a third issue at c+2.
- Simultaneous events: with done_cnt=1, sink_done and ap_continue in the same cycle leave ap_done=1 and done_cnt=1. A second continue clears ap_done.
- Error and reset: sink_done with inflight=0 sets err=1 and leaves ap_done=0. Reset asserted mid-S_ISSUE (mask=3'b001) returns all outputs to their reset values and clears err; the next iteration writes all 3 channels.
- PERF_EN build: 3 iterations, with one channel held full for 4 cycles. Result: iter_cnt=3, stall_cnt=4.
